// File: rtl/sgpio_master.sv
// sgpio_master: master end of a four-wire synchronized serial GPIO link.
// Generates o_sclk, the frame-start strobe o_sync and o_mosi from i_clk,
// shifts i_user_sw out LSB first and assembles the slave's LED byte from
// i_miso. A frame is 9 slots (sync slot + 8 data slots). Each slot is
// CLK_DIV cycles with o_sclk low, then CLK_DIV cycles with o_sclk high.
//
// Ports:
//   i_clk            system clock; all outputs are registers in this domain
//   i_rstn           asynchronous active-low reset
//   i_enable         1 = run frames back-to-back, 0 = stop at frame boundary
//   i_user_sw[7:0]   switch value sent to the slave, captured at slot-0 start
//   o_user_led[7:0]  LED value last received from the slave
//   o_user_led_valid sticky flag, set after the first complete frame
//   o_frame_done     one-cycle pulse when o_user_led updates
//   o_sclk           serial clock, low when idle
//   o_sync           high for all of slot 0
//   o_mosi           serial data to the slave, LSB first
//   i_miso           serial data from the slave, LSB first
module sgpio_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_enable,
  input  logic [7:0] i_user_sw,
  output logic [7:0] o_user_led,
  output logic       o_user_led_valid,
  output logic       o_frame_done,
  output logic       o_sclk,
  output logic       o_sync,
  output logic       o_mosi,
  input  logic       i_miso
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [3:0] slot;
  logic [7:0] div;
  logic [7:0] tx;
  logic [7:0] rx;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= IDLE;
      slot             <= '0;
      div              <= '0;
      tx               <= '0;
      rx               <= '0;
      o_user_led       <= '0;
      o_user_led_valid <= 1'b0;
      o_frame_done     <= 1'b0;
      o_sclk           <= 1'b0;
      o_sync           <= 1'b0;
      o_mosi           <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            state  <= RUN;
            slot   <= '0;
            div    <= '0;
            o_sclk <= 1'b0;
            o_sync <= 1'b1;
            o_mosi <= 1'b0;
            tx     <= i_user_sw;
          end
        end
        RUN: begin
          if (div != DIV_LAST) begin
            div <= div + 8'd1;
          end else begin
            div <= '0;
            if (!o_sclk) begin
              // Rising edge: the slave shifts on this same edge, so i_miso
              // still holds the bit it presented for this slot.
              o_sclk <= 1'b1;
              if (slot != 4'd0) rx <= {i_miso, rx[7:1]};
              if (slot == 4'd8) begin
                o_user_led       <= {i_miso, rx[7:1]};
                o_user_led_valid <= 1'b1;
                o_frame_done     <= 1'b1;
              end
            end else begin
              // Falling edge: start of the next slot; sync/mosi move only here.
              o_sclk <= 1'b0;
              if (slot == 4'd8) begin
                slot   <= '0;
                o_mosi <= 1'b0;
                if (i_enable) begin
                  o_sync <= 1'b1;
                  tx     <= i_user_sw;
                end else begin
                  o_sync <= 1'b0;
                  state  <= IDLE;
                end
              end else begin
                slot   <= slot + 4'd1;
                o_sync <= 1'b0;
                o_mosi <= tx[slot[2:0]];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgpio_master.sv
// tb_sgpio_master: bench for sgpio_master. Two instances share the clock and
// reset: dut_a with CLK_DIV=2 and dut_b with CLK_DIV=1. Each has a behavioural
// slave attached. Expected waveforms come from frame-relative cycle
// arithmetic (slot = c / (2*D), o_sclk high in the second half of a slot).
module tb_sgpio_master;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       a_en = 1'b0, b_en = 1'b0;
  logic [7:0] a_sw = '0, b_sw = '0;
  logic [7:0] a_led, b_led;
  logic       a_valid, b_valid, a_done, b_done;
  logic       a_sclk, b_sclk, a_sync, b_sync, a_mosi, b_mosi, a_miso, b_miso;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_led   [2] = '{8'h00, 8'h00};
  logic       exp_valid [2] = '{1'b0, 1'b0};
  logic [7:0] last_tx   [2] = '{8'h00, 8'h00};
  logic       chk_slave [2] = '{1'b0, 1'b0};

  sgpio_master #(.CLK_DIV(2)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_enable(a_en), .i_user_sw(a_sw),
    .o_user_led(a_led), .o_user_led_valid(a_valid), .o_frame_done(a_done),
    .o_sclk(a_sclk), .o_sync(a_sync), .o_mosi(a_mosi), .i_miso(a_miso)
  );

  sgpio_master #(.CLK_DIV(1)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_enable(b_en), .i_user_sw(b_sw),
    .o_user_led(b_led), .o_user_led_valid(b_valid), .o_frame_done(b_done),
    .o_sclk(b_sclk), .o_sync(b_sync), .o_mosi(b_mosi), .i_miso(b_miso)
  );

  always #5 clk = ~clk;

  // Slave models: on each sclk rise, the sync slot reloads the LED byte and
  // publishes the previous frame's switch byte if all 8 bits arrived.
  logic [7:0] sa_led_in = '0, sa_sh = '0, sa_rx = '0, sa_sw = '0;
  logic       sa_sw_valid = 1'b0;
  int         sa_cnt = 0;
  logic [7:0] sb_led_in = '0, sb_sh = '0, sb_rx = '0, sb_sw = '0;
  logic       sb_sw_valid = 1'b0;
  int         sb_cnt = 0;

  always @(posedge a_sclk) begin
    if (a_sync) begin
      if (sa_cnt == 8) begin
        sa_sw       <= sa_rx;
        sa_sw_valid <= 1'b1;
      end
      sa_sh  <= sa_led_in;
      sa_cnt <= 0;
    end else begin
      sa_rx  <= {a_mosi, sa_rx[7:1]};
      sa_sh  <= sa_sh >> 1;
      sa_cnt <= sa_cnt + 1;
    end
  end
  assign a_miso = sa_sh[0];

  always @(posedge b_sclk) begin
    if (b_sync) begin
      if (sb_cnt == 8) begin
        sb_sw       <= sb_rx;
        sb_sw_valid <= 1'b1;
      end
      sb_sh  <= sb_led_in;
      sb_cnt <= 0;
    end else begin
      sb_rx  <= {b_mosi, sb_rx[7:1]};
      sb_sh  <= sb_sh >> 1;
      sb_cnt <= sb_cnt + 1;
    end
  end
  assign b_miso = sb_sh[0];

  // Runs one frame on instance sel, starting at the negedge just before the
  // edge that begins slot 0. At cycle chg, i_user_sw/i_enable take new values.
  task automatic run_frame(input int sel, input logic [7:0] led, input int chg,
                           input logic [7:0] sw_new, input logic en_new);
    int         d;
    logic [7:0] tx;
    logic [7:0] prev_led;
    logic       prev_valid;
    logic       sclk_v, sync_v, mosi_v, done_v, valid_v;
    logic [7:0] led_v;
    logic       sclk_e, sync_e, mosi_e, done_e, valid_e;
    logic [7:0] led_e;
    int         slot;
    d          = (sel == 1) ? 1 : 2;
    tx         = (sel == 1) ? b_sw : a_sw;
    prev_led   = exp_led[sel];
    prev_valid = exp_valid[sel];
    if (sel == 1) sb_led_in = led; else sa_led_in = led;
    for (int c = 0; c < 18 * d; c++) begin
      @(negedge clk);
      sclk_v  = (sel == 1) ? b_sclk  : a_sclk;
      sync_v  = (sel == 1) ? b_sync  : a_sync;
      mosi_v  = (sel == 1) ? b_mosi  : a_mosi;
      done_v  = (sel == 1) ? b_done  : a_done;
      valid_v = (sel == 1) ? b_valid : a_valid;
      led_v   = (sel == 1) ? b_led   : a_led;
      slot    = c / (2 * d);
      sclk_e  = ((c / d) % 2) == 1;
      sync_e  = (slot == 0);
      mosi_e  = (slot == 0) ? 1'b0 : tx[slot - 1];
      done_e  = (c == 17 * d);
      led_e   = (c >= 17 * d) ? led : prev_led;
      valid_e = (c >= 17 * d) ? 1'b1 : prev_valid;
      total++;
      if (sclk_v !== sclk_e) begin
        bad++;
        $display("FAIL sclk dut%0d c=%0d got=%b exp=%b", sel, c, sclk_v, sclk_e);
      end
      total++;
      if (sync_v !== sync_e) begin
        bad++;
        $display("FAIL sync dut%0d c=%0d got=%b exp=%b", sel, c, sync_v, sync_e);
      end
      total++;
      if (mosi_v !== mosi_e) begin
        bad++;
        $display("FAIL mosi dut%0d c=%0d got=%b exp=%b", sel, c, mosi_v, mosi_e);
      end
      total++;
      if (done_v !== done_e) begin
        bad++;
        $display("FAIL frame_done dut%0d c=%0d got=%b exp=%b", sel, c, done_v, done_e);
      end
      total++;
      if (led_v !== led_e) begin
        bad++;
        $display("FAIL user_led dut%0d c=%0d got=%h exp=%h", sel, c, led_v, led_e);
      end
      total++;
      if (valid_v !== valid_e) begin
        bad++;
        $display("FAIL led_valid dut%0d c=%0d got=%b exp=%b", sel, c, valid_v, valid_e);
      end
      if (c == d && chk_slave[sel]) begin
        total++;
        if (((sel == 1) ? sb_sw : sa_sw) !== last_tx[sel] ||
            ((sel == 1) ? sb_sw_valid : sa_sw_valid) !== 1'b1) begin
          bad++;
          $display("FAIL slave_sw dut%0d got=%h exp=%h", sel,
                   (sel == 1) ? sb_sw : sa_sw, last_tx[sel]);
        end
      end
      if (c == chg) begin
        if (sel == 1) begin b_sw = sw_new; b_en = en_new; end
        else begin a_sw = sw_new; a_en = en_new; end
      end
    end
    exp_led[sel]   = led;
    exp_valid[sel] = 1'b1;
    last_tx[sel]   = tx;
    chk_slave[sel] = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({a_led, a_valid, a_done, a_sclk, a_sync, a_mosi} !== 13'd0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0", {a_led, a_valid, a_done, a_sclk, a_sync, a_mosi});
    end
    total++;
    if ({b_led, b_valid, b_done, b_sclk, b_sync, b_mosi} !== 13'd0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0", {b_led, b_valid, b_done, b_sclk, b_sync, b_mosi});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_frames();
    a_sw = 8'h3C;
    a_en = 1'b1;
    run_frame(0, 8'hA5, -1, 8'h00, 1'b1);
    run_frame(0, 8'($urandom), 15, 8'hFF, 1'b1);
    run_frame(0, 8'($urandom), -1, 8'h00, 1'b1);
    run_frame(0, 8'($urandom), -1, 8'h00, 1'b1);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 6; i++)
      run_frame(0, 8'($urandom), int'($urandom_range(0, 35)), 8'($urandom), 1'b1);
  endtask

  task automatic test_enable_drop();
    run_frame(0, 8'($urandom), 12, a_sw, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      total++;
      if ({a_sclk, a_sync, a_mosi, a_done} !== 4'b0 || a_led !== exp_led[0] ||
          a_valid !== exp_valid[0]) begin
        bad++;
        $display("FAIL idle i=%0d got=%b%b%b%b led=%h exp=0000 led=%h", i,
                 a_sclk, a_sync, a_mosi, a_done, a_led, exp_led[0]);
      end
    end
  endtask

  task automatic test_restart();
    a_sw = 8'($urandom);
    a_en = 1'b1;
    run_frame(0, 8'($urandom), -1, 8'h00, 1'b1);
    run_frame(0, 8'($urandom), -1, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 22; c++) @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if ({a_led, a_valid, a_done, a_sclk, a_sync, a_mosi} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", {a_led, a_valid, a_done, a_sclk, a_sync, a_mosi});
    end
    exp_led[0]   = 8'h00;
    exp_valid[0] = 1'b0;
    chk_slave[0] = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge clk);
    total++;
    if ({a_led, a_valid, a_done, a_sclk, a_sync, a_mosi} !== 13'd0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0", {a_led, a_valid, a_done, a_sclk, a_sync, a_mosi});
    end
    rstn = 1'b1;
    a_sw = 8'($urandom);
    run_frame(0, 8'($urandom), -1, 8'h00, 1'b1);
    run_frame(0, 8'($urandom), 20, 8'($urandom), 1'b0);
  endtask

  task automatic test_clkdiv1();
    b_sw = 8'($urandom);
    b_en = 1'b1;
    run_frame(1, 8'h01, -1, 8'h00, 1'b1);
    run_frame(1, 8'h80, 7, 8'($urandom), 1'b1);
    for (int i = 0; i < 4; i++)
      run_frame(1, 8'($urandom), int'($urandom_range(0, 17)), 8'($urandom), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_frames();
    test_random_frames();
    test_enable_drop();
    test_restart();
    test_reset_mid();
    test_clkdiv1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
